// File: rtl/writeback_forward_pipe_if.sv
// Bus between the execution/operand-fetch side and the writeback/forwarding pipe.
// The master is the execution side; the slave is writeback_forward_pipe.
interface writeback_forward_pipe_if #(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned ADDR_W = 7
);
  logic              stall;
  logic              resultValid;
  logic [ADDR_W-1:0] resultRT;
  logic [DATA_W-1:0] resultData;

  logic [ADDR_W-1:0] srcRA;
  logic [ADDR_W-1:0] srcRB;
  logic [ADDR_W-1:0] srcRC;
  logic [DATA_W-1:0] rfDataRA;
  logic [DATA_W-1:0] rfDataRB;
  logic [DATA_W-1:0] rfDataRC;

  logic [DATA_W-1:0] opDataRA;
  logic [DATA_W-1:0] opDataRB;
  logic [DATA_W-1:0] opDataRC;
  logic              opHitRA;
  logic              opHitRB;
  logic              opHitRC;

  logic              wbEnable;
  logic [ADDR_W-1:0] wbAddr;
  logic [DATA_W-1:0] wbData;
  logic [3:0]        inFlight;
  logic              dropError;

  modport master (
    output stall, resultValid, resultRT, resultData,
    output srcRA, srcRB, srcRC, rfDataRA, rfDataRB, rfDataRC,
    input  opDataRA, opDataRB, opDataRC, opHitRA, opHitRB, opHitRC,
    input  wbEnable, wbAddr, wbData, inFlight, dropError
  );

  modport slave (
    input  stall, resultValid, resultRT, resultData,
    input  srcRA, srcRB, srcRC, rfDataRA, rfDataRB, rfDataRC,
    output opDataRA, opDataRB, opDataRC, opHitRA, opHitRB, opHitRC,
    output wbEnable, wbAddr, wbData, inFlight, dropError
  );
endinterface

// File: rtl/writeback_forward_pipe.sv
// Fixed-depth result writeback pipeline feeding the register file write port,
// with youngest-match forwarding of in-flight results onto the RA/RB/RC operand buses.
module writeback_forward_pipe #(
  parameter int unsigned DEPTH  = 6,
  parameter int unsigned DATA_W = 128,
  parameter int unsigned ADDR_W = 7
) (
  input  logic                   clk,
  input  logic                   reset,
  writeback_forward_pipe_if.slave bus
);
  localparam int unsigned NOPS = 3;

  // Index 0 is stage 1 (youngest), index DEPTH-1 is the last stage.
  logic              vld  [DEPTH];
  logic [ADDR_W-1:0] rt   [DEPTH];
  logic [DATA_W-1:0] data [DEPTH];
  logic              dropError;
  logic [3:0]        validCount;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        vld[i]  <= 1'b0;
        rt[i]   <= '0;
        data[i] <= '0;
      end
      dropError <= 1'b0;
    end else if (bus.stall) begin
      if (bus.resultValid) begin
        dropError <= 1'b1;
      end
    end else begin
      vld[0]  <= bus.resultValid;
      rt[0]   <= bus.resultRT;
      data[0] <= bus.resultData;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        vld[i]  <= vld[i-1];
        rt[i]   <= rt[i-1];
        data[i] <= data[i-1];
      end
    end
  end

  always_comb begin
    validCount = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      validCount = validCount + 4'(vld[i]);
    end
  end

  logic [ADDR_W-1:0] src   [NOPS];
  logic [DATA_W-1:0] rfDat [NOPS];
  logic [DATA_W-1:0] opDat [NOPS];
  logic              opHit [NOPS];

  assign src[0]   = bus.srcRA;
  assign src[1]   = bus.srcRB;
  assign src[2]   = bus.srcRC;
  assign rfDat[0] = bus.rfDataRA;
  assign rfDat[1] = bus.rfDataRB;
  assign rfDat[2] = bus.rfDataRC;

  // Scan oldest to youngest so the youngest matching stage is the last to assign.
  always_comb begin
    for (int unsigned x = 0; x < NOPS; x++) begin
      opHit[x] = 1'b0;
      opDat[x] = rfDat[x];
      for (int unsigned j = 0; j < DEPTH; j++) begin
        if (vld[DEPTH-1-j] && (rt[DEPTH-1-j] == src[x])) begin
          opHit[x] = 1'b1;
          opDat[x] = data[DEPTH-1-j];
        end
      end
    end
  end

  assign bus.opDataRA  = opDat[0];
  assign bus.opDataRB  = opDat[1];
  assign bus.opDataRC  = opDat[2];
  assign bus.opHitRA   = opHit[0];
  assign bus.opHitRB   = opHit[1];
  assign bus.opHitRC   = opHit[2];

  assign bus.wbEnable  = vld[DEPTH-1] & ~bus.stall;
  assign bus.wbAddr    = rt[DEPTH-1];
  assign bus.wbData    = data[DEPTH-1];
  assign bus.inFlight  = validCount;
  assign bus.dropError = dropError;
endmodule

// File: tb/tb_writeback_forward_pipe.sv
// Randomized and directed bench for writeback_forward_pipe against a queue-based
// reference model and a behavioural register file fed by the DUT write port.
module tb_writeback_forward_pipe;
  localparam int unsigned DEPTH  = 6;
  localparam int unsigned DATA_W = 128;
  localparam int unsigned ADDR_W = 7;

  typedef struct {
    bit              v;
    bit [ADDR_W-1:0] rt;
    bit [DATA_W-1:0] d;
  } entry_t;

  logic clk;
  logic reset;

  writeback_forward_pipe_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  writeback_forward_pipe #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file: filled with random contents on the first edge, then written by the DUT.
  logic [DATA_W-1:0] rf [128];
  bit rfReady = 1'b0;
  always @(posedge clk) begin
    if (!rfReady) begin
      for (int i = 0; i < 128; i++) rf[i] <= {$urandom, $urandom, $urandom, $urandom};
      rfReady <= 1'b1;
    end else if (bus.wbEnable) begin
      rf[bus.wbAddr] <= bus.wbData;
    end
  end

  assign bus.rfDataRA = rf[bus.srcRA];
  assign bus.rfDataRB = rf[bus.srcRB];
  assign bus.rfDataRC = rf[bus.srcRC];

  // Reference model: queue of DEPTH slots, front is youngest, back is retiring.
  entry_t          pipeQ[$];
  bit              expDrop;
  bit [DATA_W-1:0] archVal [128];
  bit              archSet [128];
  int              nCompared   = 0;
  int              nMismatched = 0;
  int              maxInFlight = 0;

  task automatic checkVal(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelClear();
    pipeQ.delete();
    for (int i = 0; i < DEPTH; i++) pipeQ.push_back('{v: 1'b0, rt: '0, d: '0});
    expDrop = 1'b0;
  endtask

  task automatic modelEdge(input bit st, input bit rv, input bit [ADDR_W-1:0] rrt, input bit [DATA_W-1:0] rd);
    entry_t oldest;
    if (st) begin
      if (rv) expDrop = 1'b1;
    end else begin
      oldest = pipeQ.pop_back();
      if (oldest.v) begin
        archVal[oldest.rt] = oldest.d;
        archSet[oldest.rt] = 1'b1;
      end
      pipeQ.push_front('{v: rv, rt: rrt, d: rd});
    end
  endtask

  task automatic checkOperand(input string tag, input logic [ADDR_W-1:0] src,
                              input logic hit, input logic [DATA_W-1:0] dat);
    bit              expHit = 1'b0;
    bit [DATA_W-1:0] expDat = rf[src];
    foreach (pipeQ[i]) begin
      if (!expHit && pipeQ[i].v && pipeQ[i].rt == src) begin
        expHit = 1'b1;
        expDat = pipeQ[i].d;
      end
    end
    checkVal({tag, "Hit"}, hit, expHit);
    checkVal({tag, "Data"}, dat, expDat);
  endtask

  task automatic checkCycle();
    int cnt = 0;
    foreach (pipeQ[i]) if (pipeQ[i].v) cnt++;
    checkVal("wbEnable", bus.wbEnable, pipeQ[DEPTH-1].v && !bus.stall && !reset);
    checkVal("wbAddr", bus.wbAddr, pipeQ[DEPTH-1].rt);
    checkVal("wbData", bus.wbData, pipeQ[DEPTH-1].d);
    checkVal("inFlight", bus.inFlight, cnt);
    checkVal("dropError", bus.dropError, expDrop);
    checkOperand("opRA", bus.srcRA, bus.opHitRA, bus.opDataRA);
    checkOperand("opRB", bus.srcRB, bus.opHitRB, bus.opDataRB);
    checkOperand("opRC", bus.srcRC, bus.opHitRC, bus.opDataRC);
    if (int'(bus.inFlight) > maxInFlight) maxInFlight = int'(bus.inFlight);
  endtask

  // Entered just after a posedge; leaves just after the next posedge.
  task automatic runCycle(input bit st, input bit rv, input bit [ADDR_W-1:0] rrt, input bit [DATA_W-1:0] rd,
                          input bit [ADDR_W-1:0] sa, input bit [ADDR_W-1:0] sb, input bit [ADDR_W-1:0] sc);
    bus.stall       = st;
    bus.resultValid = rv;
    bus.resultRT    = rrt;
    bus.resultData  = rd;
    bus.srcRA       = sa;
    bus.srcRB       = sb;
    bus.srcRC       = sc;
    @(negedge clk);
    checkCycle();
    @(posedge clk);
    modelEdge(st, rv, rrt, rd);
    #1;
  endtask

  task automatic idle(input int n, input bit [ADDR_W-1:0] sa);
    for (int i = 0; i < n; i++) runCycle(1'b0, 1'b0, '0, '0, sa, 7'd1, 7'd2);
  endtask

  task automatic pulseReset();
    #1 reset = 1'b1;
    modelClear();
    #1 checkCycle();
    #1 reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.stall = 1'b0; bus.resultValid = 1'b0; bus.resultRT = '0; bus.resultData = '0;
    bus.srcRA = '0; bus.srcRB = 7'd1; bus.srcRC = 7'd2;
    for (int i = 0; i < 128; i++) begin archVal[i] = '0; archSet[i] = 1'b0; end
    modelClear();
    repeat (2) @(posedge clk);
    #1 checkCycle();
    reset = 1'b0;

    // Basic writeback: single result, rt=5, data=0x36
    runCycle(1'b0, 1'b1, 7'd5, 128'h36, 7'd5, 7'd1, 7'd2);
    idle(4, 7'd5);
    checkVal("basicInFlight", bus.inFlight, 1);
    idle(3, 7'd5);
    checkVal("basicDrained", bus.inFlight, 0);

    // Forward youngest: two writes to r9
    runCycle(1'b0, 1'b1, 7'd9, 128'hAA, 7'd9, 7'd1, 7'd2);
    runCycle(1'b0, 1'b1, 7'd9, 128'hBB, 7'd9, 7'd1, 7'd2);
    checkVal("fwdYoungestHit", bus.opHitRA, 1'b1);
    checkVal("fwdYoungestData", bus.opDataRA, 128'hBB);
    idle(DEPTH + 1, 7'd9);
    checkVal("fwdRetiredHit", bus.opHitRA, 1'b0);
    checkVal("fwdRetiredRf", rf[9], 128'hBB);

    // Three-operand hit/miss
    runCycle(1'b0, 1'b1, 7'd3, 128'h11, 7'd3, 7'd4, 7'd7);
    runCycle(1'b0, 1'b1, 7'd4, 128'h22, 7'd3, 7'd4, 7'd7);
    checkVal("triRA", bus.opDataRA, 128'h11);
    checkVal("triRB", bus.opDataRB, 128'h22);
    checkVal("triRCHit", bus.opHitRC, 1'b0);
    idle(DEPTH, 7'd3);

    // Stall with an entry in the last stage and a dropped result
    runCycle(1'b0, 1'b1, 7'd12, 128'h1234, 7'd12, 7'd1, 7'd2);
    idle(DEPTH - 1, 7'd12);
    runCycle(1'b1, 1'b0, '0, '0, 7'd12, 7'd1, 7'd2);
    runCycle(1'b1, 1'b1, 7'd13, 128'hDEAD, 7'd12, 7'd1, 7'd2);
    runCycle(1'b1, 1'b0, '0, '0, 7'd12, 7'd1, 7'd2);
    checkVal("dropSticky", bus.dropError, 1'b1);
    checkVal("stallHoldInFlight", bus.inFlight, 1);
    idle(2, 7'd12);
    checkVal("stallRetired", rf[12], 128'h1234);

    // Reset mid-flight
    for (int i = 0; i < 4; i++) runCycle(1'b0, 1'b1, 7'(20 + i), 128'(1000 + i), 7'd20, 7'd21, 7'd22);
    pulseReset();
    idle(DEPTH + 2, 7'd20);

    // Back-to-back stream of 20 results
    maxInFlight = 0;
    for (int i = 0; i < 20; i++) runCycle(1'b0, 1'b1, 7'(i), 128'(54 + 10 * i), 7'(i), 7'(i + 1), 7'd30);
    idle(DEPTH + 1, 7'd0);
    checkVal("streamSaturate", maxInFlight, DEPTH);
    checkVal("streamLast", rf[19], 128'(54 + 10 * 19));

    // Randomized traffic over a small register window to force collisions
    for (int i = 0; i < 400; i++) begin
      runCycle($urandom_range(7, 0) == 0, $urandom_range(3, 0) != 0, 7'($urandom_range(7, 0)),
               {$urandom, $urandom, $urandom, $urandom},
               7'($urandom_range(7, 0)), 7'($urandom_range(7, 0)), 7'($urandom_range(7, 0)));
      if (i == 200) pulseReset();
    end
    idle(DEPTH + 1, 7'd0);

    for (int i = 0; i < 128; i++) if (archSet[i]) checkVal("rfFinal", rf[i], archVal[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end
endmodule

// File: doc/writeback_forward_pipe.md
Name: writeback_forward_pipe

Overview:
- Result writeback and forwarding stage directly upstream of the SPU 128x128-bit register file; drives its write port (RT address, write data, write enable).
- Delays each execution result by a fixed DEPTH-stage writeback pipeline.
- While a result is in flight, forwards the newest matching value onto the RA/RB/RC operand buses in place of stale register-file read data.

Parameters:
- DEPTH, 6, number of writeback stages; legal range 2..8.
- DATA_W, 128, result/register width.
- ADDR_W, 7, register address width (128 registers).

Ports:
- clk  input  1  single clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- stall  input  1  freezes the pipeline.
- resultValid  input  1  a result is presented this cycle.
- resultRT  input  ADDR_W  destination register of the result.
- resultData  input  DATA_W  result value.
- srcRA, srcRB, srcRC  input  ADDR_W  operand register addresses, same values driven to the register file read ports.
- rfDataRA, rfDataRB, rfDataRC  input  DATA_W  register file read data.
- opDataRA, opDataRB, opDataRC  output  DATA_W  forwarded operand data.
- opHitRA, opHitRB, opHitRC  output  1  operand was taken from the pipeline.
- wbEnable  output  1  to register file write enable.
- wbAddr  output  ADDR_W  to register file RT address.
- wbData  output  DATA_W  to register file write data.
- inFlight  output  4  count of valid stages, 0..DEPTH.
- dropError  output  1  sticky: a result was lost.

Behaviour:
- State: stages 1..DEPTH, each holding {vld, rt, data}. Stage 1 is youngest.
- Async reset: all vld=0, rt=0, data=0, dropError=0.
  - Outputs during reset: wbEnable=0, wbAddr=0, wbData=0, inFlight=0, opHit*=0, opData*=rfData*.
  - Reset mid-operation discards all in-flight results. Nothing is written back.
- Advance (stall=0), every posedge:
  - stage1 <= {resultValid, resultRT, resultData}.
  - stage k <= stage k-1 for k = 2..DEPTH.
  - The last stage's contents leave the pipeline.
- Stall (stall=1):
  - All stages hold their values; wbEnable=0.
  - If resultValid=1 in a stalled cycle, the result is dropped and dropError sets on that edge. dropError stays set until reset.
- Writeback (combinational from the last stage):
  - wbEnable = vld[DEPTH] & ~stall; wbAddr = rt[DEPTH]; wbData = data[DEPTH].
  - When wbEnable=0, wbAddr and wbData still show the last-stage contents.
- Latency: a result sampled at edge E0 reaches stage DEPTH after edge E(DEPTH-1) (no stalls). wbEnable is high in the following cycle, and the register file commits at edge E(DEPTH).
- Forwarding, per operand X in {RA, RB, RC}, purely combinational:
  - Search stages 1..DEPTH for vld && rt==srcX.
  - The lowest-index (youngest) match wins.
  - On a match: opHitX=1, opDataX=that stage's data. Otherwise: opHitX=0, opDataX=rfDataX.
  - The current-cycle resultValid/resultData input is never forwarded.
  - Multiple in-flight writes to the same rt: the youngest value is forwarded. Writebacks retire in order, so the register file ends with the youngest value.
  - Forwarding remains active while stalled.
- Register 0 has no special meaning.
- inFlight = popcount of vld[1..DEPTH], updated with the stages.

Test Plan (DEPTH=6):
- Basic writeback:
  - Stimulus: resultValid=1, rt=5, data=0x36 for one cycle at edge E0, no stall.
  - Required: wbEnable=1 with wbAddr=5, wbData=0x36 only in the cycle after E5; inFlight goes 1 through E5 and returns to 0 after E6.
- Forward youngest:
  - Stimulus: rt=9 data=0xAA at E0, rt=9 data=0xBB at E1, srcRA=9.
  - Required: after E1, opDataRA=0xBB and opHitRA=1.
  - Required: writebacks of 0xAA then 0xBB on consecutive cycles; after both retire, opHitRA=0 and opDataRA=rfDataRA.
- Three-operand hit/miss:
  - Stimulus: in-flight rt=3 (0x11) and rt=4 (0x22); srcRA=3, srcRB=4, srcRC=7, rfDataRC=0x77.
  - Required: opData = 0x11 / 0x22 / 0x77; opHit = 1 / 1 / 0.
- Stall:
  - Stimulus: raise stall for 3 cycles while an entry sits in stage 6, and assert resultValid during the stall.
  - Required: wbEnable=0 and the stages hold throughout the stall; dropError=1 after the edge with resultValid; writeback occurs in the first cycle after stall drops.
- Reset mid-flight:
  - Stimulus: 4 results in flight, then pulse reset asynchronously between edges.
  - Required: inFlight=0, opHit*=0 and wbEnable=0 immediately; no writeback ever occurs for those results; dropError=0.
- Back-to-back stream:
  - Stimulus: 20 consecutive results, rt=i, data=54+10*i.
  - Required: 20 consecutive wbEnable cycles, in order, with matching wbAddr/wbData; inFlight saturates at 6.
